// File: rtl/msrh_rnid_freelist_if.sv
// Rename/commit-side handshake bundle for one lane's RNID free list.
// The rename/commit logic takes the master side; the free list takes the slave side.
interface msrh_rnid_freelist_if #(
    parameter int SIZE  = 32,
    parameter int WIDTH = 8
);
    localparam int PW = $clog2(SIZE) + 1;

    logic             i_pop;
    logic [WIDTH-1:0] o_pop_id;
    logic             o_empty;
    logic             i_push;
    logic [WIDTH-1:0] i_push_id;
    logic             o_full;
    logic             i_cmt_pop;
    logic             i_flush;
    logic [PW-1:0]    o_free_cnt;
    logic             o_err;

    modport master (
        output i_pop, i_push, i_push_id, i_cmt_pop, i_flush,
        input  o_pop_id, o_empty, o_full, o_free_cnt, o_err
    );

    modport slave (
        input  i_pop, i_push, i_push_id, i_cmt_pop, i_flush,
        output o_pop_id, o_empty, o_full, o_free_cnt, o_err
    );
endinterface

// File: rtl/msrh_rnid_freelist.sv
// Per-lane RNID free list: speculative head for rename, committed head for
// flush rollback, tail for IDs returned at commit.
module msrh_rnid_freelist #(
    parameter int SIZE      = 32,
    parameter int WIDTH     = 8,
    parameter int INIT_BASE = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    msrh_rnid_freelist_if.slave   fl
);
    localparam int PW = $clog2(SIZE) + 1;
    localparam int IW = PW - 1;
    localparam logic [PW-1:0] SIZE_P = PW'(SIZE);

    logic [WIDTH-1:0] entry [SIZE];
    logic [PW-1:0]    r_head, r_cmt_head, r_tail;
    logic             r_err;

    logic empty, full;
    logic pop_ok, push_ok, cmt_ok, err_nxt;
    logic [PW-1:0] head_nxt;

    assign empty = (r_head == r_tail);
    assign full  = ((r_tail - r_cmt_head) == SIZE_P);

    assign pop_ok  = fl.i_pop && !empty && !fl.i_flush;
    assign push_ok = fl.i_push && !full;
    assign cmt_ok  = fl.i_cmt_pop && (r_cmt_head != r_head);

    // A pop discarded by flush is not an error; only a pop against an empty list is.
    assign err_nxt = (fl.i_pop && empty && !fl.i_flush) ||
                     (fl.i_push && full) ||
                     (fl.i_cmt_pop && !cmt_ok);

    always_comb begin
        head_nxt = r_head;
        if (fl.i_flush)
            head_nxt = r_cmt_head + PW'(cmt_ok);
        else if (pop_ok)
            head_nxt = r_head + PW'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < SIZE; k++)
                entry[k] <= WIDTH'(INIT_BASE + k);
            r_head     <= '0;
            r_cmt_head <= '0;
            r_tail     <= SIZE_P;
            r_err      <= 1'b0;
        end else begin
            // Push can never land on [cmt_head, head): full blocks it, so rollback is safe.
            if (push_ok) begin
                entry[r_tail[IW-1:0]] <= fl.i_push_id;
                r_tail <= r_tail + PW'(1);
            end
            if (cmt_ok)
                r_cmt_head <= r_cmt_head + PW'(1);
            r_head <= head_nxt;
            r_err  <= err_nxt;
        end
    end

    assign fl.o_pop_id   = entry[r_head[IW-1:0]];
    assign fl.o_empty    = empty;
    assign fl.o_full     = full;
    assign fl.o_free_cnt = r_tail - r_head;
    assign fl.o_err      = r_err;
endmodule

// File: tb/tb_msrh_rnid_freelist.sv
// Directed bench for msrh_rnid_freelist (SIZE=32, WIDTH=8, INIT_BASE=32).
module tb_msrh_rnid_freelist;
    logic i_clk = 1'b0;
    logic i_reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 i_clk = ~i_clk;

    msrh_rnid_freelist_if #(.SIZE(32), .WIDTH(8)) fl ();

    msrh_rnid_freelist #(.SIZE(32), .WIDTH(8), .INIT_BASE(32)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .fl      (fl)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        fl.i_pop = 0; fl.i_push = 0; fl.i_push_id = '0;
        fl.i_cmt_pop = 0; fl.i_flush = 0;
    endtask

    task automatic do_reset();
        idle();
        i_reset = 1;
        step();
        step();
        i_reset = 0;
    endtask

    initial begin
        i_reset = 1;
        idle();
        do_reset();

        // reset state
        chk("rst_pop_id", int'(fl.o_pop_id), 32);
        chk("rst_free", int'(fl.o_free_cnt), 32);
        chk("rst_empty", int'(fl.o_empty), 0);
        chk("rst_full", int'(fl.o_full), 1);
        chk("rst_err", int'(fl.o_err), 0);

        // push while full: dropped, error pulse, contents unchanged
        fl.i_push = 1; fl.i_push_id = 8'd7;
        step();
        idle();
        chk("full_push_err", int'(fl.o_err), 1);
        chk("full_push_id", int'(fl.o_pop_id), 32);
        chk("full_push_free", int'(fl.o_free_cnt), 32);
        step();
        chk("full_push_err_clr", int'(fl.o_err), 0);

        // drain 32..63
        for (int i = 0; i < 32; i++) begin
            fl.i_pop = 1;
            chk($sformatf("drain_id%0d", i), int'(fl.o_pop_id), 32 + i);
            step();
        end
        chk("drain_empty", int'(fl.o_empty), 1);
        chk("drain_free", int'(fl.o_free_cnt), 0);
        chk("drain_err", int'(fl.o_err), 0);
        step();
        idle();
        chk("pop_empty_err", int'(fl.o_err), 1);
        chk("pop_empty_free", int'(fl.o_free_cnt), 0);
        chk("pop_empty_empty", int'(fl.o_empty), 1);
        step();
        chk("pop_empty_err_clr", int'(fl.o_err), 0);

        // flush with nothing committed recovers everything
        fl.i_flush = 1;
        step();
        idle();
        chk("flush_all_free", int'(fl.o_free_cnt), 32);
        chk("flush_all_id", int'(fl.o_pop_id), 32);

        // rollback: pop 32,33,34; commit one; flush
        fl.i_pop = 1;
        repeat (3) step();
        idle();
        fl.i_cmt_pop = 1;
        step();
        idle();
        fl.i_flush = 1;
        step();
        idle();
        chk("rb_id", int'(fl.o_pop_id), 33);
        chk("rb_free", int'(fl.o_free_cnt), 31);
        fl.i_flush = 1;
        step();
        idle();
        chk("rb2_id", int'(fl.o_pop_id), 33);
        chk("rb2_free", int'(fl.o_free_cnt), 31);
        chk("rb2_err", int'(fl.o_err), 0);

        // flush + cmt_pop + pop in one cycle after two pops
        do_reset();
        fl.i_pop = 1;
        repeat (2) step();
        fl.i_pop = 1; fl.i_cmt_pop = 1; fl.i_flush = 1;
        step();
        idle();
        chk("fcp_id", int'(fl.o_pop_id), 33);
        chk("fcp_free", int'(fl.o_free_cnt), 31);
        chk("fcp_err", int'(fl.o_err), 0);

        // recycle: pop and commit everything, then push id 5
        do_reset();
        for (int i = 0; i < 33; i++) begin
            fl.i_pop = (i < 32);
            fl.i_cmt_pop = (i > 0);
            step();
        end
        idle();
        chk("rc_err", int'(fl.o_err), 0);
        chk("rc_empty", int'(fl.o_empty), 1);
        chk("rc_full", int'(fl.o_full), 0);
        fl.i_push = 1; fl.i_push_id = 8'd5;
        chk("rc_empty_during_push", int'(fl.o_empty), 1);
        step();
        idle();
        chk("rc_empty_after", int'(fl.o_empty), 0);
        chk("rc_id", int'(fl.o_pop_id), 5);
        chk("rc_free", int'(fl.o_free_cnt), 1);

        // async reset mid-burst
        do_reset();
        for (int i = 0; i < 11; i++) begin
            fl.i_pop = (i < 10);
            fl.i_cmt_pop = (i > 0);
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            fl.i_push = 1; fl.i_push_id = 8'(100 + i);
            step();
        end
        idle();
        chk("burst_free", int'(fl.o_free_cnt), 26);
        chk("burst_id", int'(fl.o_pop_id), 42);
        #3;
        i_reset = 1;
        #1;
        chk("arst_id", int'(fl.o_pop_id), 32);
        chk("arst_free", int'(fl.o_free_cnt), 32);
        chk("arst_empty", int'(fl.o_empty), 0);
        chk("arst_full", int'(fl.o_full), 1);
        chk("arst_err", int'(fl.o_err), 0);
        @(negedge i_clk);
        i_reset = 0;
        fl.i_pop = 1;
        chk("arst_pop_id", int'(fl.o_pop_id), 32);
        step();
        idle();
        chk("arst_pop_next", int'(fl.o_pop_id), 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
